// File: rtl/lcd_hd44780_rx_model_if.sv
// 4-bit HD44780 pin bundle between an LCD driver (master) and the LCD model (slave).
interface lcd_hd44780_rx_model_if;
    logic       rs;
    logic       rw;
    logic       en;
    logic [3:0] LCD_in;
    logic [3:0] LCD_rd;
    logic       LCD_oe;

    modport master (output rs, rw, en, LCD_in, input  LCD_rd, LCD_oe);
    modport slave  (input  rs, rw, en, LCD_in, output LCD_rd, LCD_oe);
endinterface

// File: rtl/lcd_hd44780_rx_model.sv
// HD44780 controller-side model: 4-bit bus capture, instruction decode, DDRAM, busy flag.
// Optional 64x8 CGRAM storage when LCD_MODEL_CGRAM_EN is defined.
module lcd_hd44780_rx_model #(
    parameter int BUSY_CYCLES      = 480,
    parameter int BUSY_LONG_CYCLES = 19680
) (
    input  logic        Clk,
    input  logic        Rst,
    lcd_hd44780_rx_model_if.slave lcd,
    output logic        cmd_valid,
    output logic        cmd_rs,
    output logic [7:0]  cmd_byte,
    output logic        protocol_err,
    output logic        busy,
    output logic [6:0]  ac,
    output logic        disp_on,
    output logic        cursor_on,
    output logic        blink_on,
    output logic        two_line,
    output logic [5:0]  shift_ofs,
    input  logic [6:0]  dbg_addr,
    output logic [7:0]  dbg_data
);
    localparam int CMAX = (BUSY_LONG_CYCLES > BUSY_CYCLES) ? BUSY_LONG_CYCLES : BUSY_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    logic [6:0]    sync1_q, sync2_q;
    logic          en3_q;
    logic          phase_q, phase_d;
    logic [3:0]    hi_nib_q, hi_nib_d;
    logic          hi_rs_q, hi_rs_d, hi_rw_q, hi_rw_d;
    logic [6:0]    ac_q, ac_d;
    logic          tgt_cg_q, tgt_cg_d, id_q, id_d, s_q, s_d;
    logic          disp_q, disp_d, cur_q, cur_d, blink_q, blink_d, two_line_q, two_line_d;
    logic [5:0]    shift_q, shift_d;
    logic [CW-1:0] busy_cnt_q, busy_cnt_d;
    logic          fill_q, fill_d;
    logic [6:0]    fill_addr_q, fill_addr_d;
    logic          cmd_valid_q, cmd_valid_d, cmd_rs_q, cmd_rs_d, perr_q, perr_d;
    logic [7:0]    cmd_byte_q, cmd_byte_d;
    logic [3:0]    rd_q, rd_d;
    logic          oe_q, oe_d;
    logic [7:0]    dbg_data_q;

    logic [7:0]    ddram_mem [0:127];
    logic          mem_we;
    logic [6:0]    mem_waddr;
    logic [7:0]    mem_wdata;
    logic [7:0]    byte_w;
    logic          rs_s, rw_s, en_s, en_rise, en_fall, busy_now;
    logic [3:0]    nib_s;
`ifdef LCD_MODEL_CGRAM_EN
    logic [7:0]    cgram_mem [0:63];
    logic          cg_we;
`endif

    assign rs_s     = sync2_q[6];
    assign rw_s     = sync2_q[5];
    assign en_s     = sync2_q[4];
    assign nib_s    = sync2_q[3:0];
    assign en_rise  = en_s & ~en3_q;
    assign en_fall  = ~en_s & en3_q;
    assign busy_now = (busy_cnt_q != '0) || fill_q;
    assign byte_w   = {hi_nib_q, nib_s};

    // Two-line mode walks 0x00-0x27 then 0x40-0x67; out-of-range addresses snap back in.
    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up,
                                           input logic cg, input logic two);
        logic [6:0] r;
        if (cg)
            r = {1'b0, up ? (a[5:0] + 6'd1) : (a[5:0] - 6'd1)};
        else if (two) begin
            if (up)
                r = (a < 7'h27) ? a + 7'd1 : (a < 7'h40) ? 7'h40 : (a < 7'h67) ? a + 7'd1 : 7'h00;
            else
                r = (a == 7'h00) ? 7'h67 : (a <= 7'h27) ? a - 7'd1 :
                    (a <= 7'h40) ? 7'h27 : (a <= 7'h67) ? a - 7'd1 : 7'h67;
        end else begin
            if (up)
                r = (a >= 7'h4F) ? 7'h00 : a + 7'd1;
            else
                r = (a == 7'h00 || a > 7'h4F) ? 7'h4F : a - 7'd1;
        end
        return r;
    endfunction

    function automatic logic [5:0] ofs_step(input logic [5:0] o, input logic up);
        if (up)
            return (o >= 6'd39) ? 6'd0 : o + 6'd1;
        else
            return (o == 6'd0 || o > 6'd39) ? 6'd39 : o - 6'd1;
    endfunction

    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync1_q <= '0; sync2_q <= '0; en3_q <= 1'b0;
            phase_q <= 1'b1; hi_nib_q <= '0; hi_rs_q <= 1'b0; hi_rw_q <= 1'b0;
            ac_q <= '0; tgt_cg_q <= 1'b0; id_q <= 1'b1; s_q <= 1'b0;
            disp_q <= 1'b0; cur_q <= 1'b0; blink_q <= 1'b0; two_line_q <= 1'b0;
            shift_q <= '0; busy_cnt_q <= '0; fill_q <= 1'b0; fill_addr_q <= '0;
            cmd_valid_q <= 1'b0; cmd_rs_q <= 1'b0; cmd_byte_q <= '0; perr_q <= 1'b0;
            rd_q <= '0; oe_q <= 1'b0;
        end else begin
            sync1_q <= {lcd.rs, lcd.rw, lcd.en, lcd.LCD_in};
            sync2_q <= sync1_q; en3_q <= sync2_q[4];
            phase_q <= phase_d; hi_nib_q <= hi_nib_d; hi_rs_q <= hi_rs_d; hi_rw_q <= hi_rw_d;
            ac_q <= ac_d; tgt_cg_q <= tgt_cg_d; id_q <= id_d; s_q <= s_d;
            disp_q <= disp_d; cur_q <= cur_d; blink_q <= blink_d; two_line_q <= two_line_d;
            shift_q <= shift_d; busy_cnt_q <= busy_cnt_d; fill_q <= fill_d; fill_addr_q <= fill_addr_d;
            cmd_valid_q <= cmd_valid_d; cmd_rs_q <= cmd_rs_d; cmd_byte_q <= cmd_byte_d; perr_q <= perr_d;
            rd_q <= rd_d; oe_q <= oe_d;
        end
    end

    always_comb begin
        phase_d = phase_q; hi_nib_d = hi_nib_q; hi_rs_d = hi_rs_q; hi_rw_d = hi_rw_q;
        ac_d = ac_q; tgt_cg_d = tgt_cg_q; id_d = id_q; s_d = s_q;
        disp_d = disp_q; cur_d = cur_q; blink_d = blink_q; two_line_d = two_line_q;
        shift_d = shift_q; busy_cnt_d = busy_cnt_q; fill_d = fill_q; fill_addr_d = fill_addr_q;
        cmd_valid_d = 1'b0; cmd_rs_d = cmd_rs_q; cmd_byte_d = cmd_byte_q; perr_d = 1'b0;
        rd_d = rd_q; oe_d = oe_q;
        mem_we = 1'b0; mem_waddr = fill_addr_q; mem_wdata = 8'h20;
`ifdef LCD_MODEL_CGRAM_EN
        cg_we = 1'b0;
`endif
        if (busy_cnt_q != '0)
            busy_cnt_d = busy_cnt_q - CW'(1);
        // Clear fill owns the write port; writes arriving meanwhile are rejected as busy.
        if (fill_q) begin
            mem_we      = 1'b1;
            fill_addr_d = fill_addr_q + 7'd1;
            if (fill_addr_q == 7'h7F)
                fill_d = 1'b0;
        end
        if (en_fall)
            oe_d = 1'b0;
        if (en_rise) begin
            phase_d = ~phase_q;
            if (phase_q) begin
                hi_nib_d = nib_s; hi_rs_d = rs_s; hi_rw_d = rw_s;
            end
            if (rw_s) begin
                oe_d = 1'b1;
                if (rs_s) begin
                    rd_d = 4'h0; perr_d = 1'b1;
                end else
                    rd_d = phase_q ? {busy_now, ac_q[6:4]} : ac_q[3:0];
            end
            if (!phase_q) begin
                if ((rs_s != hi_rs_q) || (rw_s != hi_rw_q))
                    perr_d = 1'b1;
                else if (!rw_s) begin
                    cmd_valid_d = 1'b1; cmd_rs_d = rs_s; cmd_byte_d = byte_w;
                    if (busy_now)
                        perr_d = 1'b1;
                    else begin
                        busy_cnt_d = CW'(BUSY_CYCLES);
                        if (rs_s) begin
                            if (!tgt_cg_q) begin
                                mem_we = 1'b1; mem_waddr = ac_q; mem_wdata = byte_w;
                            end
`ifdef LCD_MODEL_CGRAM_EN
                            else
                                cg_we = 1'b1;
`endif
                            ac_d = ac_step(ac_q, id_q, tgt_cg_q, two_line_q);
                            if (s_q)
                                shift_d = ofs_step(shift_q, id_q);
                        end else if (byte_w[7]) begin
                            ac_d = byte_w[6:0]; tgt_cg_d = 1'b0;
                        end else if (byte_w[6]) begin
                            ac_d = {1'b0, byte_w[5:0]}; tgt_cg_d = 1'b1;
                        end else if (byte_w[5]) begin
                            two_line_d = byte_w[3];
                        end else if (byte_w[4]) begin
                            if (byte_w[3])
                                shift_d = ofs_step(shift_q, byte_w[2]);
                            else
                                ac_d = ac_step(ac_q, byte_w[2], tgt_cg_q, two_line_q);
                        end else if (byte_w[3]) begin
                            disp_d = byte_w[2]; cur_d = byte_w[1]; blink_d = byte_w[0];
                        end else if (byte_w[2]) begin
                            id_d = byte_w[1]; s_d = byte_w[0];
                        end else if (byte_w[1]) begin
                            ac_d = '0; shift_d = '0; busy_cnt_d = CW'(BUSY_LONG_CYCLES);
                        end else if (byte_w[0]) begin
                            ac_d = '0; id_d = 1'b1; shift_d = '0;
                            fill_d = 1'b1; fill_addr_d = '0;
                            busy_cnt_d = CW'(BUSY_LONG_CYCLES);
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (mem_we)
            ddram_mem[mem_waddr] <= mem_wdata;
        dbg_data_q <= ddram_mem[dbg_addr];
    end

`ifdef LCD_MODEL_CGRAM_EN
    always_ff @(posedge Clk) begin
        if (cg_we)
            cgram_mem[ac_q[5:0]] <= byte_w;
    end
`endif

    assign cmd_valid    = cmd_valid_q;
    assign cmd_rs       = cmd_rs_q;
    assign cmd_byte     = cmd_byte_q;
    assign protocol_err = perr_q;
    assign busy         = busy_now;
    assign ac           = ac_q;
    assign disp_on      = disp_q;
    assign cursor_on    = cur_q;
    assign blink_on     = blink_q;
    assign two_line     = two_line_q;
    assign shift_ofs    = shift_q;
    assign dbg_data     = dbg_data_q;
    assign lcd.LCD_rd   = rd_q;
    assign lcd.LCD_oe   = oe_q;
endmodule

// File: tb/tb_lcd_hd44780_rx_model.sv
// Self-checking bench for lcd_hd44780_rx_model: drives the 4-bit bus like an LCD driver.
module tb_lcd_hd44780_rx_model;
    localparam int BUSY_C = 60;
    localparam int BUSY_L = 100;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       cmd_valid, cmd_rs, protocol_err, busy;
    logic       disp_on, cursor_on, blink_on, two_line;
    logic [7:0] cmd_byte, dbg_data;
    logic [6:0] ac;
    logic [6:0] dbg_addr = 7'h00;
    logic [5:0] shift_ofs;

    always #5 Clk = ~Clk;

    lcd_hd44780_rx_model_if bus ();

    lcd_hd44780_rx_model #(.BUSY_CYCLES(BUSY_C), .BUSY_LONG_CYCLES(BUSY_L)) dut (
        .Clk(Clk), .Rst(Rst), .lcd(bus),
        .cmd_valid(cmd_valid), .cmd_rs(cmd_rs), .cmd_byte(cmd_byte),
        .protocol_err(protocol_err), .busy(busy), .ac(ac),
        .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .two_line(two_line), .shift_ofs(shift_ofs),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [8:0] exp_q[$];
    logic [8:0] sb_exp;
    int         perr_cnt = 0;
    int         busy_run = 0;
    int         busy_len_last = 0;
    logic       busy_prev = 1'b0;

    // Scoreboard for completed bytes, plus protocol-error and busy-length bookkeeping.
    always @(negedge Clk) begin
        if (!Rst) begin
            if (cmd_valid === 1'b1) begin
                $display("cmd rs=%0d byte=%02h busy=%0d", cmd_rs, cmd_byte, busy);
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL cmd_unexpected: got rs=%0d byte=%02h, required none", cmd_rs, cmd_byte);
                end else begin
                    sb_exp = exp_q.pop_front();
                    if ({cmd_rs, cmd_byte} !== sb_exp) begin
                        n_fail++;
                        $display("FAIL cmd_byte: got %03h, required %03h", {cmd_rs, cmd_byte}, sb_exp);
                    end
                end
            end
            if (protocol_err === 1'b1) perr_cnt++;
            if (cmd_valid === 1'b1) busy_run = (busy === 1'b1) ? 1 : 0;
            else if (busy === 1'b1) busy_run++;
            if (busy_prev === 1'b1 && busy !== 1'b1) busy_len_last = busy_run;
            busy_prev = busy;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic nibble(input logic r_s, input logic r_w, input logic [3:0] n,
                          output logic [3:0] rd_s, output logic oe_hi, output logic oe_lo);
        @(negedge Clk);
        bus.rs = r_s; bus.rw = r_w; bus.LCD_in = n;
        repeat (2) @(negedge Clk);
        bus.en = 1'b1;
        repeat (8) @(negedge Clk);
        rd_s = bus.LCD_rd; oe_hi = bus.LCD_oe;
        bus.en = 1'b0;
        repeat (6) @(negedge Clk);
        oe_lo = bus.LCD_oe;
    endtask

    task automatic write_byte(input logic r_s, input logic [7:0] b);
        logic [3:0] rd_s;
        logic       oh, ol;
        exp_q.push_back({r_s, b});
        nibble(r_s, 1'b0, b[7:4], rd_s, oh, ol);
        nibble(r_s, 1'b0, b[3:0], rd_s, oh, ol);
    endtask

    task automatic wait_not_busy(input string tag);
        int k = 0;
        while (busy !== 1'b0 && k < 3000) begin
            @(negedge Clk);
            k++;
        end
        if (k >= 3000) begin
            n_fail++;
            $display("FAIL busy_timeout %s: busy=%b, required 0 within 3000 cycles", tag, busy);
        end
        @(negedge Clk);
    endtask

    task automatic cmd(input logic [7:0] b);
        write_byte(1'b0, b);
        wait_not_busy("cmd");
    endtask

    task automatic data(input logic [7:0] b);
        write_byte(1'b1, b);
        wait_not_busy("data");
    endtask

    task automatic dbg_read(input logic [6:0] a, output logic [7:0] d);
        @(negedge Clk);
        dbg_addr = a;
        @(negedge Clk);
        d = dbg_data;
    endtask

    task automatic test_reset;
        logic [3:0] rd_s;
        logic       oh, ol;
        logic [36:0] outs;
        bus.rs = 1'b0; bus.rw = 1'b0; bus.en = 1'b0; bus.LCD_in = 4'h0;
        Rst = 1'b1;
        repeat (4) @(negedge Clk);
        outs = {cmd_valid, cmd_rs, cmd_byte, protocol_err, busy, ac, disp_on, cursor_on,
                blink_on, two_line, shift_ofs, bus.LCD_rd, bus.LCD_oe};
        n_checks++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, required 0", outs);
        end
        Rst = 1'b0;
        write_byte(1'b0, 8'h0F);
        n_checks++;
        if (busy !== 1'b1 || disp_on !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_after_write: got busy=%b disp=%b, required 1 1", busy, disp_on);
        end
        nibble(1'b0, 1'b0, 4'h3, rd_s, oh, ol);
        @(negedge Clk) Rst = 1'b1;
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        outs = {cmd_valid, cmd_rs, cmd_byte, protocol_err, busy, ac, disp_on, cursor_on,
                blink_on, two_line, shift_ofs, bus.LCD_rd, bus.LCD_oe};
        n_checks++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got %h, required 0", outs);
        end
    endtask

    task automatic test_init;
        logic [7:0] d;
        cmd(8'h28); cmd(8'h06); cmd(8'h0E); cmd(8'h01);
        n_checks++;
        if ({two_line, disp_on, cursor_on, blink_on, ac} !== {4'b1110, 7'h00}) begin
            n_fail++;
            $display("FAIL init_flags: got tl/d/c/b=%b ac=%02h, required 1110 ac=00",
                     {two_line, disp_on, cursor_on, blink_on}, ac);
        end
        n_checks++;
        if (busy_len_last < 104) begin
            n_fail++;
            $display("FAIL clear_busy_len: got %0d cycles, required >= 104", busy_len_last);
        end
        for (int i = 0; i < 40; i++) begin
            dbg_read(7'(i), d);
            n_checks++;
            if (d !== 8'h20) begin
                n_fail++;
                $display("FAIL clear_ddram[%02h]: got %02h, required 20", i, d);
            end
            dbg_read(7'(i + 'h40), d);
            n_checks++;
            if (d !== 8'h20) begin
                n_fail++;
                $display("FAIL clear_ddram[%02h]: got %02h, required 20", i + 'h40, d);
            end
        end
    endtask

    task automatic test_welcome;
        string      msg = "WELCOME";
        logic [7:0] d;
        logic [3:0] rd_s;
        logic       oh, ol;
        for (int i = 0; i < 7; i++) begin
            data(msg[i]);
            if (i == 0) begin
                n_checks++;
                if (busy_len_last != BUSY_C) begin
                    n_fail++;
                    $display("FAIL write_busy_len: got %0d, required %0d", busy_len_last, BUSY_C);
                end
            end
        end
        n_checks++;
        if (ac !== 7'h07) begin
            n_fail++;
            $display("FAIL welcome_ac: got %02h, required 07", ac);
        end
        for (int i = 0; i < 7; i++) begin
            dbg_read(7'(i), d);
            n_checks++;
            if (d !== msg[i]) begin
                n_fail++;
                $display("FAIL welcome_ddram[%0d]: got %02h, required %02h", i, d, msg[i]);
            end
        end
        dbg_read(7'h03, d);
        n_checks++;
        if (d !== 8'h43) begin
            n_fail++;
            $display("FAIL dbg_addr3: got %02h, required 43", d);
        end
        nibble(1'b0, 1'b1, 4'h0, rd_s, oh, ol);
        n_checks++;
        if ({rd_s, oh, ol} !== {4'h0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL read_hi_idle: got rd=%h oe=%b/%b, required 0 1/0", rd_s, oh, ol);
        end
        nibble(1'b0, 1'b1, 4'h0, rd_s, oh, ol);
        n_checks++;
        if ({rd_s, oh} !== {4'h7, 1'b1}) begin
            n_fail++;
            $display("FAIL read_lo_ac: got rd=%h oe=%b, required 7 1", rd_s, oh);
        end
    endtask

    task automatic test_ddram_wrap;
        logic [7:0] d;
        cmd(8'hA7);
        n_checks++;
        if (ac !== 7'h27) begin
            n_fail++;
            $display("FAIL set_ddram_ac: got %02h, required 27", ac);
        end
        data("X");
        dbg_read(7'h27, d);
        n_checks++;
        if (ac !== 7'h40 || d !== "X") begin
            n_fail++;
            $display("FAIL wrap_inc: got ac=%02h d=%02h, required ac=40 d=58", ac, d);
        end
        cmd(8'h04);
        data("Y");
        dbg_read(7'h40, d);
        n_checks++;
        if (ac !== 7'h27 || d !== "Y") begin
            n_fail++;
            $display("FAIL wrap_dec: got ac=%02h d=%02h, required ac=27 d=59", ac, d);
        end
        cmd(8'h06);
    endtask

    task automatic test_shift;
        cmd(8'h1C); cmd(8'h1C);
        n_checks++;
        if (shift_ofs !== 6'd2) begin
            n_fail++;
            $display("FAIL shift_right: got %0d, required 2", shift_ofs);
        end
        cmd(8'h18); cmd(8'h18); cmd(8'h18);
        n_checks++;
        if (shift_ofs !== 6'd39) begin
            n_fail++;
            $display("FAIL shift_left_wrap: got %0d, required 39", shift_ofs);
        end
        cmd(8'h02);
        n_checks++;
        if (shift_ofs !== 6'd0 || ac !== 7'h00 || busy_len_last != BUSY_L) begin
            n_fail++;
            $display("FAIL home: got ofs=%0d ac=%02h busy_len=%0d, required 0 00 %0d",
                     shift_ofs, ac, busy_len_last, BUSY_L);
        end
    endtask

    task automatic test_busy_reject;
        int         p0;
        logic [7:0] d;
        logic [3:0] rd_s;
        logic       oh, ol;
        p0 = perr_cnt;
        write_byte(1'b0, 8'h01);
        write_byte(1'b1, "Z");
        n_checks++;
        if (perr_cnt != p0 + 1) begin
            n_fail++;
            $display("FAIL busy_write_err: got %0d pulses, required 1", perr_cnt - p0);
        end
        nibble(1'b0, 1'b1, 4'h0, rd_s, oh, ol);
        n_checks++;
        if (rd_s[3] !== 1'b1 || oh !== 1'b1 || ol !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_flag_read: got rd=%h oe=%b/%b, required bit3=1 oe 1/0", rd_s, oh, ol);
        end
        nibble(1'b0, 1'b1, 4'h0, rd_s, oh, ol);
        wait_not_busy("clear");
        dbg_read(7'h00, d);
        n_checks++;
        if (d !== 8'h20 || ac !== 7'h00) begin
            n_fail++;
            $display("FAIL busy_write_dropped: got d=%02h ac=%02h, required 20 00", d, ac);
        end
    endtask

    task automatic test_mismatch;
        int         p0;
        logic [3:0] rd_s;
        logic       oh, ol;
        p0 = perr_cnt;
        nibble(1'b0, 1'b0, 4'h0, rd_s, oh, ol);
        nibble(1'b1, 1'b0, 4'hC, rd_s, oh, ol);
        n_checks++;
        if (perr_cnt != p0 + 1) begin
            n_fail++;
            $display("FAIL mismatch_err: got %0d pulses, required 1", perr_cnt - p0);
        end
        cmd(8'h0C);
        n_checks++;
        if ({disp_on, cursor_on, blink_on} !== 3'b100) begin
            n_fail++;
            $display("FAIL after_mismatch: got %b, required 100", {disp_on, cursor_on, blink_on});
        end
    endtask

    task automatic test_cgram;
        logic [7:0] d;
        cmd(8'h40);
        n_checks++;
        if (ac !== 7'h00) begin
            n_fail++;
            $display("FAIL cgram_addr: got %02h, required 00", ac);
        end
        data("N");
        dbg_read(7'h00, d);
        n_checks++;
        if (ac !== 7'h01 || d !== 8'h20) begin
            n_fail++;
            $display("FAIL cgram_write: got ac=%02h ddram0=%02h, required 01 20", ac, d);
        end
`ifdef LCD_MODEL_CGRAM_EN
        n_checks++;
        if (dut.cgram_mem[0] !== 8'h4E) begin
            n_fail++;
            $display("FAIL cgram_store: got %02h, required 4e", dut.cgram_mem[0]);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_init();
        test_welcome();
        test_ddram_wrap();
        test_shift();
        test_busy_reject();
        test_mismatch();
        test_cgram();
        repeat (4) @(negedge Clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL cmd_missing: got %0d unreported bytes, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
